rgb565_video_driver: RTL and testbench

Generates 1280x720@60 raster timing in the pixel clock domain and returns pixel coordinates to the colour-bar/pattern generator. It then drives the pattern generator's returned RGB565 data onto the SiI9134 parallel input together with hsync, vsync and DE. It accounts for the generator's one-cycle registered latency: coordinates are issued one clock ahead of DE, so the returned pixel_data lines up with DE.

---
 rtl/rgb565_video_driver.sv | 94 +++++++++
 tb/tb_rgb565_video_driver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rgb565_video_driver.sv
`default_nettype none
// ============================================================================
// Module   : rgb565_video_driver
// Brief    : 720p60 raster timing generator; requests pixels one clock ahead
//            of DE and drives RGB565 + syncs to the parallel transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module rgb565_video_driver #(
   parameter logic [10:0] H_SYNC   = 11'd40,
   parameter logic [10:0] H_BACK   = 11'd220,
   parameter logic [10:0] H_DISP   = 11'd1280,
   parameter logic [10:0] H_FRONT  = 11'd110,
   parameter logic [10:0] H_TOTAL  = 11'd1650,
   parameter logic [10:0] V_SYNC   = 11'd5,
   parameter logic [10:0] V_BACK   = 11'd20,
   parameter logic [10:0] V_DISP   = 11'd720,
   parameter logic [10:0] V_FRONT  = 11'd5,
   parameter logic [10:0] V_TOTAL  = 11'd750,
   parameter logic        SYNC_POL = 1'b1
) (
   input  logic        pixel_clk,
   input  logic        sys_rst_n,
   input  logic [15:0] pixel_data,
   output logic [10:0] pixel_xpos,
   output logic [10:0] pixel_ypos,
   output logic        video_hs,
   output logic        video_vs,
   output logic        video_de,
   output logic [15:0] video_rgb,
   output logic        frame_start
);

   localparam logic [10:0] c_H_ACT_BEG = H_SYNC + H_BACK;
   localparam logic [10:0] c_H_ACT_END = H_SYNC + H_BACK + H_DISP;
   localparam logic [10:0] c_H_REQ_BEG = c_H_ACT_BEG - 11'd1;
   localparam logic [10:0] c_H_REQ_END = c_H_ACT_END - 11'd2;
   localparam logic [10:0] c_V_ACT_BEG = V_SYNC + V_BACK;
   localparam logic [10:0] c_V_ACT_END = V_SYNC + V_BACK + V_DISP;

   logic [10:0] r_h_cnt;
   logic [10:0] r_v_cnt;
   logic        r_frame_start;

   logic w_h_last;
   logic w_v_last;
   logic w_h_act;
   logic w_v_act;
   logic w_data_req;
   logic w_fs_next;

   // H_FRONT/V_FRONT are implied by the totals; kept for documentation only.
   logic [21:0] w_unused;
   assign w_unused = {H_FRONT, V_FRONT};

   assign w_h_last = (r_h_cnt == H_TOTAL - 11'd1);
   assign w_v_last = (r_v_cnt == V_TOTAL - 11'd1);

   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (w_h_last) begin
         r_h_cnt <= '0;
         r_v_cnt <= w_v_last ? 11'd0 : r_v_cnt + 11'd1;
      end else begin
         r_h_cnt <= r_h_cnt + 11'd1;
      end
   end

   assign w_v_act    = (r_v_cnt >= c_V_ACT_BEG) && (r_v_cnt < c_V_ACT_END);
   assign w_h_act    = (r_h_cnt >= c_H_ACT_BEG) && (r_h_cnt < c_H_ACT_END);
   assign w_data_req = w_v_act && (r_h_cnt >= c_H_REQ_BEG) && (r_h_cnt <= c_H_REQ_END);

   // Registered from the request cycle so the pulse lands on the first DE clock.
   assign w_fs_next = (r_v_cnt == c_V_ACT_BEG) && (r_h_cnt == c_H_REQ_BEG);

   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_fs_next;
      end
   end

   assign pixel_xpos  = w_data_req ? (r_h_cnt - c_H_REQ_BEG) : 11'd0;
   assign pixel_ypos  = w_data_req ? (r_v_cnt - c_V_ACT_BEG) : 11'd0;
   assign video_de    = w_h_act && w_v_act;
   assign video_hs    = (r_h_cnt < H_SYNC) ? SYNC_POL : ~SYNC_POL;
   assign video_vs    = (r_v_cnt < V_SYNC) ? SYNC_POL : ~SYNC_POL;
   assign video_rgb   = video_de ? pixel_data : 16'h0000;
   assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_rgb565_video_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb565_video_driver
// Brief    : Bench for rgb565_video_driver on a scaled-down raster with a
//            random-LUT registered pattern generator and an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb565_video_driver;

   localparam int HS = 4;
   localparam int HB = 6;
   localparam int HD = 16;
   localparam int HF = 5;
   localparam int HT = HS + HB + HD + HF;
   localparam int VS = 2;
   localparam int VB = 3;
   localparam int VD = 8;
   localparam int VF = 2;
   localparam int VT = VS + VB + VD + VF;
   localparam int FT = HT * VT;
   localparam int FIRST_DE = (VS + VB) * HT + HS + HB;

   logic        clk;
   logic        rst_n;
   logic [15:0] pixel_data;
   logic [10:0] pixel_xpos;
   logic [10:0] pixel_ypos;
   logic        video_hs;
   logic        video_vs;
   logic        video_de;
   logic [15:0] video_rgb;
   logic        frame_start;

   logic [15:0] lut [16];
   int n_assert = 0;
   int n_fail   = 0;
   int t        = 0;
   int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0;
   bit seen_de = 0;

   rgb565_video_driver #(
      .H_SYNC(11'(HS)), .H_BACK(11'(HB)), .H_DISP(11'(HD)), .H_FRONT(11'(HF)),
      .H_TOTAL(11'(HT)), .V_SYNC(11'(VS)), .V_BACK(11'(VB)), .V_DISP(11'(VD)),
      .V_FRONT(11'(VF)), .V_TOTAL(11'(VT)), .SYNC_POL(1'b1)
   ) dut (
      .pixel_clk  (clk),
      .sys_rst_n  (rst_n),
      .pixel_data (pixel_data),
      .pixel_xpos (pixel_xpos),
      .pixel_ypos (pixel_ypos),
      .video_hs   (video_hs),
      .video_vs   (video_vs),
      .video_de   (video_de),
      .video_rgb  (video_rgb),
      .frame_start(frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pattern generator stand-in: one-cycle registered lookup of the coordinates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pixel_data <= '0;
      else        pixel_data <= lut[pixel_xpos[3:0]] ^ {5'd0, pixel_ypos};
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, exp, t);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_hs"},  16'(video_hs), 16'd1);
      chk({tag, "_vs"},  16'(video_vs), 16'd1);
      chk({tag, "_de"},  16'(video_de), 16'd0);
      chk({tag, "_rgb"}, video_rgb, 16'd0);
      chk({tag, "_x"},   16'(pixel_xpos), 16'd0);
      chk({tag, "_y"},   16'(pixel_ypos), 16'd0);
      chk({tag, "_fs"},  16'(frame_start), 16'd0);
   endtask

   // Expected behaviour derived from elapsed clocks since reset release.
   task automatic check_model();
      int  h, v;
      bit  vact, hact, req;
      logic [15:0] ex, ey, ergb;
      h    = t % HT;
      v    = (t / HT) % VT;
      vact = (v >= VS + VB) && (v < VS + VB + VD);
      hact = (h >= HS + HB) && (h < HS + HB + HD);
      req  = vact && (h >= HS + HB - 1) && (h <= HS + HB + HD - 2);
      ex   = req ? 16'(h - (HS + HB - 1)) : 16'd0;
      ey   = req ? 16'(v - (VS + VB)) : 16'd0;
      ergb = (vact && hact) ? (lut[h - (HS + HB)] ^ 16'(v - (VS + VB))) : 16'd0;
      chk("hs",   16'(video_hs), 16'(h < HS));
      chk("vs",   16'(video_vs), 16'(v < VS));
      chk("de",   16'(video_de), 16'(vact && hact));
      chk("xpos", 16'(pixel_xpos), ex);
      chk("ypos", 16'(pixel_ypos), ey);
      chk("rgb",  video_rgb, ergb);
      chk("fs",   16'(frame_start), 16'((h == HS + HB) && (v == VS + VB)));
      if (video_de && !seen_de) begin
         seen_de = 1;
         chk("first_de_t", 16'(t), 16'(FIRST_DE));
      end
      de_cnt += int'(video_de);
      hs_cnt += int'(video_hs);
      vs_cnt += int'(video_vs);
      fs_cnt += int'(frame_start);
      if ((t % FT) == FT - 1) begin
         chk("frame_de_cnt", 16'(de_cnt), 16'(HD * VD));
         chk("frame_hs_cnt", 16'(hs_cnt), 16'(HS * VT));
         chk("frame_vs_cnt", 16'(vs_cnt), 16'(VS * HT));
         chk("frame_fs_cnt", 16'(fs_cnt), 16'd1);
         de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n   = 1'b1;
      t       = 0;
      seen_de = 0;
      de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
      check_model();
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         t++;
         check_model();
      end
   endtask

   initial begin
      int hold, target_h, guard;
      rst_n = 1'b0;
      for (int i = 0; i < 16; i++) lut[i] = 16'($urandom) | 16'h0001;

      // Power-on reset of random length, checked every clock.
      hold = int'($urandom_range(5, 10));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk_reset_vals("por");
      end
      release_reset();

      // Two full frames plus a little of the third, covering the frame wrap.
      step(2 * FT + 3 * HT);

      // Reset in the middle of an active line at a random column.
      target_h = int'($urandom_range(HS + HB + 1, HS + HB + HD - 2));
      guard = 0;
      while (!(((t / HT) % VT) == 7 && (t % HT) == target_h) && guard < FT) begin
         step(1);
         guard++;
      end
      chk("mid_reset_reached", 16'(guard < FT), 16'd1);
      chk("mid_reset_de_before", 16'(video_de), 16'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_reset_vals("mid");
      end
      release_reset();

      // Full frame after release: restart from 0 with a complete blanking sequence.
      step(FT + HT);
      chk("saw_de_after_mid_reset", 16'(seen_de), 16'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
